// File: rtl/pipe_pkg.sv
// Shared widths and control-field layout for the MIPS pipeline stage registers.
package pipe_pkg;

    localparam int CTRL_W = 7;
    localparam int DATA_W = 134;
    localparam int CNT_W  = 16;

    // Control field layout: {WB_EN, MEM_W_EN, MEM_R_EN, EXE_CMD[3:0]}
    localparam int EXE_CMD_LSB = 0;
    localparam int EXE_CMD_W   = 4;
    localparam int MEM_R_BIT   = 4;
    localparam int MEM_W_BIT   = 5;
    localparam int WB_BIT      = 6;

    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_DATA_W  = 134;
    localparam int EX_MEM_DATA_W = 69;
    localparam int MEM_WB_DATA_W = 69;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
    parameter int CNT_W = pipe_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush-to-bubble and stall counter.
// Define PIPE_STAGE_SKID_EN for a 1-entry skid slot and a registered in_ready.
module pipe_stage_reg #(
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int CNT_W  = pipe_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stat_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_valid_d;
    logic              out_valid_q;
    logic [CTRL_W-1:0] out_ctrl_d;
    logic [CTRL_W-1:0] out_ctrl_q;
    logic [DATA_W-1:0] out_data_d;
    logic [DATA_W-1:0] out_data_q;

    logic accept;
    logic emit;
    logic stall;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid_q && out_ready;
    assign stall  = out_valid_q && !out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_d;
    logic              skid_valid_q;
    logic [CTRL_W-1:0] skid_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_d;
    logic [DATA_W-1:0] skid_data_q;

    // Skid occupancy is a flop, so out_ready never reaches in_ready.
    assign in_ready = !skid_valid_q;

    // Main/skid next state: skid drains first, so acceptance order is kept.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_ctrl_d   = out_ctrl_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_ctrl_d   = '0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || emit) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_ctrl_d   = skid_ctrl_q;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_ctrl_d  = in_ctrl;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
                out_ctrl_d  = '0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end else begin
            skid_valid_d = skid_valid_q;
        end
    end

    // Skid slot registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    // Main register next state; accept implies main is empty or emitting.
    always_comb begin
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = '0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = in_ctrl;
            out_data_d  = in_data;
        end else if (emit) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = '0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end
`endif

    // Main output registers; data is only ever cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_data  = out_data_q;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall),
        .clr (stat_clr),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps then random traffic
// against a queue-based model of the stage contents.
module tb_pipe_stage_reg;

    localparam int CW = 7;
    localparam int DW = 134;
    localparam int NW = 3;
    localparam int CNT_MAX = (1 << NW) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          stat_clr;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stat_clr  (stat_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    // Model: beats held in the stage, oldest first, plus the last main data.
    beat_t         mq[$];
    logic [DW-1:0] m_data;
    int            m_cnt;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 256'(out_valid), 256'(mq.size() > 0));
        chk({tag, ".out_ctrl"},  256'(out_ctrl),  256'((mq.size() > 0) ? mq[0].c : {CW{1'b0}}));
        chk({tag, ".out_data"},  256'(out_data),  256'(m_data));
        chk({tag, ".stall_cnt"}, 256'(stall_cnt), 256'(m_cnt));
    endtask

    task automatic model_reset();
        mq.delete();
        m_data = '0;
        m_cnt  = 0;
    endtask

    // One clock: drive at negedge, check in_ready, advance model, check after edge.
    task automatic step(input string tag, input bit fl, input bit cl, input bit iv,
                        input logic [CW-1:0] c, input logic [DW-1:0] d, input bit ordy);
        bit    rdy;
        bit    acc;
        beat_t b;
        @(negedge clk);
        flush     = fl;
        stat_clr  = cl;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        #1;
        rdy = (CAP == 2) ? (mq.size() < 2) : ((mq.size() == 0) || ordy);
        chk({tag, ".in_ready"}, 256'(in_ready), 256'(rdy));
        acc = iv && rdy;
        if (cl) m_cnt = 0;
        else if ((mq.size() > 0) && !ordy && (m_cnt < CNT_MAX)) m_cnt++;
        if ((mq.size() > 0) && ordy) void'(mq.pop_front());
        b.c = c;
        b.d = d;
        if (acc) mq.push_back(b);
        if (fl) mq.delete();
        if (mq.size() > 0) m_data = mq[0].d;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        flush = 1'b0; stat_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        chk({tag, ".in_ready"}, 256'(in_ready), 256'(1'b1));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs({tag, ".release"});
        chk({tag, ".in_ready_rel"}, 256'(in_ready), 256'(1'b1));
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    initial begin
        logic [DW-1:0] a;
        logic [DW-1:0] zd;
        zd = '0;
        rst = 1'b0; flush = 1'b0; stat_clr = 1'b0; in_valid = 1'b0;
        in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #3;
        check_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Streaming, back-to-back emit and accept.
        for (int i = 1; i <= 8; i++) begin
            step("stream", 1'b0, 1'b0, 1'b1, 7'h7f, DW'(i), 1'b1);
            chk("stream.data_i", 256'(out_data), 256'(i));
            chk("stream.ctrl", 256'(out_ctrl), 256'(7'h7f));
        end
        step("drain", 1'b0, 1'b0, 1'b0, 7'h00, zd, 1'b1);

        // Stall for five cycles with a beat held.
        a = rand_data();
        step("load", 1'b0, 1'b1, 1'b1, 7'h15, a, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step("stall", 1'b0, 1'b0, 1'b1, 7'(i + 1), DW'(100 + i), 1'b0);
        end
        chk("stall.cnt5", 256'(stall_cnt), 256'(5));
        chk("stall.data_held", 256'(out_data), 256'(a));
        for (int i = 0; i < 3; i++) begin
            step("release", 1'b0, 1'b0, 1'b0, 7'h00, zd, 1'b1);
        end

        // Flush with a valid output and a beat arriving in the same cycle.
        step("preflush", 1'b0, 1'b0, 1'b1, 7'h3c, rand_data(), 1'b0);
        step("flush", 1'b1, 1'b0, 1'b1, 7'h55, rand_data(), 1'b0);
        chk("flush.valid", 256'(out_valid), 256'(1'b0));
        chk("flush.ctrl", 256'(out_ctrl), 256'(7'h00));
        step("postflush", 1'b0, 1'b0, 1'b0, 7'h00, zd, 1'b1);
        step("postflush", 1'b0, 1'b0, 1'b0, 7'h00, zd, 1'b1);

        // Saturation and clear during a stall.
        step("satload", 1'b0, 1'b1, 1'b1, 7'h41, rand_data(), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step("sat", 1'b0, 1'b0, 1'b0, 7'h00, zd, 1'b0);
        end
        chk("sat.cnt7", 256'(stall_cnt), 256'(7));
        step("clr", 1'b0, 1'b1, 1'b0, 7'h00, zd, 1'b0);
        chk("clr.zero", 256'(stall_cnt), 256'(0));
        step("resume", 1'b0, 1'b0, 1'b0, 7'h00, zd, 1'b0);
        chk("resume.one", 256'(stall_cnt), 256'(1));
        step("satdrain", 1'b0, 1'b0, 1'b0, 7'h00, zd, 1'b1);

        // Random traffic with occasional flush, clear and a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset("midreset");
            end
            step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0), 7'($urandom), rand_data(),
                 ($urandom_range(0, 4) < 3));
        end

        do_reset("endreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the MIPS core, the generalised successor of the fixed-field ID/EX latch. Carries a control field and a data field between adjacent stages with a valid/ready handshake, stall back-pressure and flush-to-bubble. It also keeps a saturating stall-cycle counter. One instance is placed between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB), each with its own widths.

## Interface
- CTRL_W, 7: control bits (EXE_CMD[3:0], MEM_R_EN, MEM_W_EN, WB_EN); forced to 0 in every bubble.
- DATA_W, 134: data bits (Dest, Reg2, Val2, Val1, PC, Br_taken); never cleared except by reset.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  kill stage contents and any beat accepted this cycle.
- stat_clr  in  1  synchronous clear of stall_cnt.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_ctrl  in  CTRL_W  upstream control.
- in_data  in  DATA_W  upstream data.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  registered control; 0 whenever out_valid=0.
- out_data  out  DATA_W  registered data.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- **Accept and emit:**
  - Input is accepted when in_valid && in_ready.
  - Output is emitted when out_valid && out_ready.
- **Main register:**
  - Loads the accepted beat when it is empty or emitting this cycle.
  - After an emit with no new load: out_valid←0, out_ctrl←0, out_data holds.
- **Flush (highest priority):**
  - Sets out_valid←0 and out_ctrl←0, and empties the skid slot.
  - A beat accepted in the same cycle is dropped.
  - in_ready is unaffected by flush.
- **Stall counter:**
  - Increments every cycle with out_valid && !out_ready.
  - Sticks at 2^CNT_W−1.
  - stat_clr takes priority over increment; the counter reads 0 next cycle.
  - Flush does not clear the counter, and a flush-cycle stall still counts.
- **Ordering:** beats leave in acceptance order. No beat is duplicated or lost except through flush.

## Timing
- Reset (rst=0, asynchronous):
  - out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid empty.
  - in_ready=1 immediately after reset.
- Latency: a beat accepted at edge N appears on out_* after edge N; one-cycle latency when unstalled.
- Throughput: 1 beat/cycle while out_ready=1.
- Reset mid-stall or mid-transfer: all contents are discarded. Upstream must re-present its beat.
- in_ready: combinational or registered, depending on configuration (see below).

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - Adds a 1-entry skid slot; in_ready is registered and equals !skid_valid.
  - A beat accepted while main is full and stalled goes to the skid slot.
  - On the next emit, the skid moves into main; new input is then accepted the following cycle.
  - Up to two beats may be held; there is no combinational path from out_ready to in_ready.
- Undefined:
  - Single register; in_ready = !out_valid || out_ready (combinational).
  - At most one beat held.

## Structure
- Shared package pipe_pkg holds:
  - Default widths: CTRL_W, DATA_W, CNT_W.
  - Control bit positions: EXE_CMD_LSB, MEM_R_BIT, MEM_W_BIT, WB_BIT.
  - Per-stage DATA_W constants.
- One sub-module, pipe_sat_counter: CNT_W saturating counter with inc and clr inputs, used for stall_cnt.

## Test plan
- **Reset:** reset mid-traffic, release → out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1.
- **Streaming:** stream 8 beats (data 0x1..0x8, ctrl 0x7F) with out_ready=1 → same beats one cycle later, one per cycle, in order.
- **Stall:** hold out_ready=0 for 5 cycles with a beat held → out_data stable, stall_cnt=5. Without skid, in_ready=0; with skid, one extra beat is absorbed, then in_ready=0. Release → no loss, order preserved.
- **Flush:** pulse flush while out_valid=1 and in_valid=1 → next cycle out_valid=0, out_ctrl=0. The flushed and incoming beats never appear.
- **Counter saturation and clear:** CNT_W=3, stall 10 cycles → stall_cnt=7. Then stat_clr → 0 the next cycle.
- **Simultaneous events:** emit and accept in the same cycle → back-to-back beats, no bubble. stat_clr during a stall → 0 then resumes from 1.
